// File: rtl/ddr_stats_counters.sv
`default_nettype none
// ============================================================================
// Module : ddr_stats_counters
// Passive two-stage statistics counters for one S2MM/MM2S datamover pair.
// Rev    : 1.0  initial release
// ============================================================================
module ddr_stats_counters #(
   parameter int CMD_WIDTH = 72,
   parameter int BTT_WIDTH = 23,
   parameter int STS_WIDTH = 8
) (
   input  logic                 mem_clk,
   input  logic                 mem_rst,
   input  logic                 stats_clear,
   input  logic                 wr_cmd_tvalid,
   input  logic                 wr_cmd_tready,
   input  logic [CMD_WIDTH-1:0] wr_cmd_tdata,
   input  logic                 wr_data_tvalid,
   input  logic                 wr_data_tready,
   input  logic                 wr_data_tlast,
   input  logic                 wr_sts_tvalid,
   input  logic                 wr_sts_tready,
   input  logic [STS_WIDTH-1:0] wr_sts_tdata,
   input  logic                 rd_cmd_tvalid,
   input  logic                 rd_cmd_tready,
   input  logic [CMD_WIDTH-1:0] rd_cmd_tdata,
   input  logic                 rd_data_tvalid,
   input  logic                 rd_data_tready,
   input  logic                 rd_data_tlast,
   input  logic                 rd_sts_tvalid,
   input  logic                 rd_sts_tready,
   input  logic [STS_WIDTH-1:0] rd_sts_tdata,
   output logic [31:0]          write_cmd_counter,
   output logic [31:0]          write_word_counter,
   output logic [31:0]          write_pkg_counter,
   output logic [47:0]          write_length_counter,
   output logic [31:0]          write_sts_counter,
   output logic [31:0]          write_sts_error_counter,
   output logic [31:0]          read_cmd_counter,
   output logic [31:0]          read_word_counter,
   output logic [31:0]          read_pkg_counter,
   output logic [47:0]          read_length_counter,
   output logic [31:0]          read_sts_counter,
   output logic [31:0]          read_sts_error_counter
);

   // Stage-1 event flag bit positions within each path's flag vector
   localparam int EV_CMD  = 0;
   localparam int EV_WORD = 1;
   localparam int EV_PKG  = 2;
   localparam int EV_STS  = 3;
   localparam int EV_ERR  = 4;

   logic [4:0]           wr_ev_d, wr_ev_q, rd_ev_d, rd_ev_q;
   logic [BTT_WIDTH-1:0] wr_btt_d, wr_btt_q, rd_btt_d, rd_btt_q;

   logic [31:0] write_cmd_d, write_cmd_q, write_word_d, write_word_q;
   logic [31:0] write_pkg_d, write_pkg_q, write_sts_d, write_sts_q;
   logic [31:0] write_err_d, write_err_q;
   logic [47:0] write_length_d, write_length_q;
   logic [31:0] read_cmd_d, read_cmd_q, read_word_d, read_word_q;
   logic [31:0] read_pkg_d, read_pkg_q, read_sts_d, read_sts_q;
   logic [31:0] read_err_d, read_err_q;
   logic [47:0] read_length_d, read_length_q;

   // Only the BTT field and the status OK bit carry information here
   logic unused_taps;
   assign unused_taps = ^{wr_cmd_tdata, rd_cmd_tdata, wr_sts_tdata, rd_sts_tdata};

   always_comb begin
      wr_ev_d  = '0;
      rd_ev_d  = '0;
      wr_btt_d = wr_cmd_tdata[BTT_WIDTH-1:0];
      rd_btt_d = rd_cmd_tdata[BTT_WIDTH-1:0];
      if (!stats_clear) begin
         wr_ev_d[EV_CMD]  = wr_cmd_tvalid & wr_cmd_tready;
         wr_ev_d[EV_WORD] = wr_data_tvalid & wr_data_tready;
         wr_ev_d[EV_PKG]  = wr_data_tvalid & wr_data_tready & wr_data_tlast;
         wr_ev_d[EV_STS]  = wr_sts_tvalid & wr_sts_tready;
         wr_ev_d[EV_ERR]  = wr_sts_tvalid & wr_sts_tready & ~wr_sts_tdata[7];
         rd_ev_d[EV_CMD]  = rd_cmd_tvalid & rd_cmd_tready;
         rd_ev_d[EV_WORD] = rd_data_tvalid & rd_data_tready;
         rd_ev_d[EV_PKG]  = rd_data_tvalid & rd_data_tready & rd_data_tlast;
         rd_ev_d[EV_STS]  = rd_sts_tvalid & rd_sts_tready;
         rd_ev_d[EV_ERR]  = rd_sts_tvalid & rd_sts_tready & ~rd_sts_tdata[7];
      end
   end

   always_comb begin
      write_cmd_d    = write_cmd_q  + 32'(wr_ev_q[EV_CMD]);
      write_word_d   = write_word_q + 32'(wr_ev_q[EV_WORD]);
      write_pkg_d    = write_pkg_q  + 32'(wr_ev_q[EV_PKG]);
      write_sts_d    = write_sts_q  + 32'(wr_ev_q[EV_STS]);
      write_err_d    = write_err_q  + 32'(wr_ev_q[EV_ERR]);
      write_length_d = write_length_q + (wr_ev_q[EV_CMD] ? 48'(wr_btt_q) : 48'd0);
      read_cmd_d     = read_cmd_q   + 32'(rd_ev_q[EV_CMD]);
      read_word_d    = read_word_q  + 32'(rd_ev_q[EV_WORD]);
      read_pkg_d     = read_pkg_q   + 32'(rd_ev_q[EV_PKG]);
      read_sts_d     = read_sts_q   + 32'(rd_ev_q[EV_STS]);
      read_err_d     = read_err_q   + 32'(rd_ev_q[EV_ERR]);
      read_length_d  = read_length_q + (rd_ev_q[EV_CMD] ? 48'(rd_btt_q) : 48'd0);
      if (stats_clear) begin
         write_cmd_d    = '0;
         write_word_d   = '0;
         write_pkg_d    = '0;
         write_sts_d    = '0;
         write_err_d    = '0;
         write_length_d = '0;
         read_cmd_d     = '0;
         read_word_d    = '0;
         read_pkg_d     = '0;
         read_sts_d     = '0;
         read_err_d     = '0;
         read_length_d  = '0;
      end
   end

   always_ff @(posedge mem_clk) begin
      if (mem_rst) begin
         wr_ev_q        <= '0;
         rd_ev_q        <= '0;
         wr_btt_q       <= '0;
         rd_btt_q       <= '0;
         write_cmd_q    <= '0;
         write_word_q   <= '0;
         write_pkg_q    <= '0;
         write_sts_q    <= '0;
         write_err_q    <= '0;
         write_length_q <= '0;
         read_cmd_q     <= '0;
         read_word_q    <= '0;
         read_pkg_q     <= '0;
         read_sts_q     <= '0;
         read_err_q     <= '0;
         read_length_q  <= '0;
      end else begin
         wr_ev_q        <= wr_ev_d;
         rd_ev_q        <= rd_ev_d;
         wr_btt_q       <= wr_btt_d;
         rd_btt_q       <= rd_btt_d;
         write_cmd_q    <= write_cmd_d;
         write_word_q   <= write_word_d;
         write_pkg_q    <= write_pkg_d;
         write_sts_q    <= write_sts_d;
         write_err_q    <= write_err_d;
         write_length_q <= write_length_d;
         read_cmd_q     <= read_cmd_d;
         read_word_q    <= read_word_d;
         read_pkg_q     <= read_pkg_d;
         read_sts_q     <= read_sts_d;
         read_err_q     <= read_err_d;
         read_length_q  <= read_length_d;
      end
   end

   assign write_cmd_counter       = write_cmd_q;
   assign write_word_counter      = write_word_q;
   assign write_pkg_counter       = write_pkg_q;
   assign write_length_counter    = write_length_q;
   assign write_sts_counter       = write_sts_q;
   assign write_sts_error_counter = write_err_q;
   assign read_cmd_counter        = read_cmd_q;
   assign read_word_counter       = read_word_q;
   assign read_pkg_counter        = read_pkg_q;
   assign read_length_counter     = read_length_q;
   assign read_sts_counter        = read_sts_q;
   assign read_sts_error_counter  = read_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr_stats_counters.sv
`default_nettype none
// ============================================================================
// Module : tb_ddr_stats_counters
// Directed bench with an event-log reference model for ddr_stats_counters.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ddr_stats_counters;

   localparam int NC   = 12;
   localparam int MAXE = 4096;

   logic        mem_clk = 1'b0;
   logic        mem_rst, stats_clear;
   logic        wr_cmd_tvalid, wr_cmd_tready, wr_data_tvalid, wr_data_tready, wr_data_tlast;
   logic        wr_sts_tvalid, wr_sts_tready;
   logic [71:0] wr_cmd_tdata;
   logic [7:0]  wr_sts_tdata;
   logic        rd_cmd_tvalid, rd_cmd_tready, rd_data_tvalid, rd_data_tready, rd_data_tlast;
   logic        rd_sts_tvalid, rd_sts_tready;
   logic [71:0] rd_cmd_tdata;
   logic [7:0]  rd_sts_tdata;
   logic [31:0] write_cmd_counter, write_word_counter, write_pkg_counter;
   logic [31:0] write_sts_counter, write_sts_error_counter;
   logic [47:0] write_length_counter, read_length_counter;
   logic [31:0] read_cmd_counter, read_word_counter, read_pkg_counter;
   logic [31:0] read_sts_counter, read_sts_error_counter;

   int errors = 0;
   int checks = 0;

   ddr_stats_counters dut (
      .mem_clk(mem_clk), .mem_rst(mem_rst), .stats_clear(stats_clear),
      .wr_cmd_tvalid(wr_cmd_tvalid), .wr_cmd_tready(wr_cmd_tready), .wr_cmd_tdata(wr_cmd_tdata),
      .wr_data_tvalid(wr_data_tvalid), .wr_data_tready(wr_data_tready), .wr_data_tlast(wr_data_tlast),
      .wr_sts_tvalid(wr_sts_tvalid), .wr_sts_tready(wr_sts_tready), .wr_sts_tdata(wr_sts_tdata),
      .rd_cmd_tvalid(rd_cmd_tvalid), .rd_cmd_tready(rd_cmd_tready), .rd_cmd_tdata(rd_cmd_tdata),
      .rd_data_tvalid(rd_data_tvalid), .rd_data_tready(rd_data_tready), .rd_data_tlast(rd_data_tlast),
      .rd_sts_tvalid(rd_sts_tvalid), .rd_sts_tready(rd_sts_tready), .rd_sts_tdata(rd_sts_tdata),
      .write_cmd_counter(write_cmd_counter), .write_word_counter(write_word_counter),
      .write_pkg_counter(write_pkg_counter), .write_length_counter(write_length_counter),
      .write_sts_counter(write_sts_counter), .write_sts_error_counter(write_sts_error_counter),
      .read_cmd_counter(read_cmd_counter), .read_word_counter(read_word_counter),
      .read_pkg_counter(read_pkg_counter), .read_length_counter(read_length_counter),
      .read_sts_counter(read_sts_counter), .read_sts_error_counter(read_sts_error_counter)
   );

   always #5 mem_clk = ~mem_clk;

   // Reference: a log of per-edge event totals. After edge e a counter holds
   // its base value plus every event sampled from base_edge up to edge e-1.
   longint psum [0:MAXE-1][0:NC-1];
   longint base_val [0:NC-1];
   int     base_edge [0:NC-1];
   int     e = 0;

   function automatic longint tap_event(int k);
      case (k)
         0:  return longint'(wr_cmd_tvalid & wr_cmd_tready);
         1:  return longint'(wr_data_tvalid & wr_data_tready);
         2:  return longint'(wr_data_tvalid & wr_data_tready & wr_data_tlast);
         3:  return (wr_cmd_tvalid & wr_cmd_tready) ? longint'(wr_cmd_tdata[22:0]) : 64'd0;
         4:  return longint'(wr_sts_tvalid & wr_sts_tready);
         5:  return longint'(wr_sts_tvalid & wr_sts_tready & !wr_sts_tdata[7]);
         6:  return longint'(rd_cmd_tvalid & rd_cmd_tready);
         7:  return longint'(rd_data_tvalid & rd_data_tready);
         8:  return longint'(rd_data_tvalid & rd_data_tready & rd_data_tlast);
         9:  return (rd_cmd_tvalid & rd_cmd_tready) ? longint'(rd_cmd_tdata[22:0]) : 64'd0;
         10: return longint'(rd_sts_tvalid & rd_sts_tready);
         default: return longint'(rd_sts_tvalid & rd_sts_tready & !rd_sts_tdata[7]);
      endcase
   endfunction

   function automatic longint dut_val(int k);
      case (k)
         0:  return longint'(write_cmd_counter);
         1:  return longint'(write_word_counter);
         2:  return longint'(write_pkg_counter);
         3:  return longint'(write_length_counter);
         4:  return longint'(write_sts_counter);
         5:  return longint'(write_sts_error_counter);
         6:  return longint'(read_cmd_counter);
         7:  return longint'(read_word_counter);
         8:  return longint'(read_pkg_counter);
         9:  return longint'(read_length_counter);
         10: return longint'(read_sts_counter);
         default: return longint'(read_sts_error_counter);
      endcase
   endfunction

   function automatic longint model_val(int k);
      longint s;
      longint m;
      m = (k == 3 || k == 9) ? 64'hFFFF_FFFF_FFFF : 64'hFFFF_FFFF;
      if (base_edge[k] > e) s = 0;
      else s = psum[e-1][k] - psum[base_edge[k]-1][k];
      return (base_val[k] + s) & m;
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   initial begin
      for (int k = 0; k < NC; k++) begin
         psum[0][k]   = 0;
         base_val[k]  = 0;
         base_edge[k] = 1;
      end
   end

   always @(posedge mem_clk) begin
      if (e < MAXE - 1) begin
         e = e + 1;
         for (int k = 0; k < NC; k++) psum[e][k] = psum[e-1][k] + tap_event(k);
         if (mem_rst || stats_clear)
            for (int k = 0; k < NC; k++) begin
               base_val[k]  = 0;
               base_edge[k] = e + 1;
            end
      end
   end

   always @(posedge mem_clk) begin
      #2;
      if (e > 0)
         for (int k = 0; k < NC; k++) chk($sformatf("model[%0d]", k), dut_val(k), model_val(k));
   end

   task automatic tick();
      @(negedge mem_clk);
   endtask

   task automatic idle();
      wr_cmd_tvalid = 0; wr_cmd_tready = 0; wr_cmd_tdata = '0;
      wr_data_tvalid = 0; wr_data_tready = 0; wr_data_tlast = 0;
      wr_sts_tvalid = 0; wr_sts_tready = 0; wr_sts_tdata = '0;
      rd_cmd_tvalid = 0; rd_cmd_tready = 0; rd_cmd_tdata = '0;
      rd_data_tvalid = 0; rd_data_tready = 0; rd_data_tlast = 0;
      rd_sts_tvalid = 0; rd_sts_tready = 0; rd_sts_tdata = '0;
   endtask

   task automatic do_clear();
      tick(); idle(); stats_clear = 1;
      tick(); stats_clear = 0;
      tick();
   endtask

   int btts  [4] = '{64, 999, 128, 4096};
   bit rdy   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
   bit [7:0] rsts [3] = '{8'h80, 8'h00, 8'h40};

   initial begin
      int beats;
      int i;
      mem_rst = 1; stats_clear = 0; idle();
      // Reset with all taps toggling
      for (int c = 0; c < 4; c++) begin
         tick();
         {wr_cmd_tvalid, wr_cmd_tready, wr_data_tvalid, wr_data_tready, wr_data_tlast,
          wr_sts_tvalid, wr_sts_tready, rd_cmd_tvalid, rd_cmd_tready, rd_data_tvalid,
          rd_data_tready, rd_data_tlast, rd_sts_tvalid, rd_sts_tready} = 14'($urandom);
         wr_cmd_tdata = 72'({$urandom, $urandom, $urandom});
         rd_cmd_tdata = 72'({$urandom, $urandom, $urandom});
         wr_sts_tdata = 8'($urandom);
         rd_sts_tdata = 8'($urandom);
      end
      chk("rst_write_length", longint'(write_length_counter), 0);
      chk("rst_read_word", longint'(read_word_counter), 0);
      tick(); mem_rst = 0; idle();
      wr_cmd_tvalid = 1; wr_cmd_tready = 1; wr_cmd_tdata = 72'd7;
      @(posedge mem_clk); #2;
      chk("first_beat_not_yet", longint'(write_cmd_counter), 0);
      idle();
      @(posedge mem_clk); #2;
      chk("first_beat_cmd", longint'(write_cmd_counter), 1);
      chk("first_beat_len", longint'(write_length_counter), 7);

      // Write traffic with stalls
      do_clear();
      for (int c = 0; c < 4; c++) begin
         tick(); idle();
         wr_cmd_tvalid = 1; wr_cmd_tready = rdy[c]; wr_cmd_tdata = 72'(btts[c]);
      end
      beats = 0; i = 0;
      while (beats < 70) begin
         tick(); idle();
         wr_data_tvalid = 1;
         if (i % 8 == 7) begin
            wr_data_tready = 0; wr_data_tlast = 1;
         end else begin
            wr_data_tready = 1;
            beats++;
            wr_data_tlast = (beats == 20 || beats == 50 || beats == 70);
         end
         i++;
      end
      for (int c = 0; c < 3; c++) begin
         tick(); idle(); wr_sts_tvalid = 1; wr_sts_tready = 1; wr_sts_tdata = 8'h80;
      end
      tick(); idle(); tick(); tick();
      chk("wr_cmd", longint'(write_cmd_counter), 3);
      chk("wr_length", longint'(write_length_counter), 4288);
      chk("wr_word", longint'(write_word_counter), 70);
      chk("wr_pkg", longint'(write_pkg_counter), 3);
      chk("wr_sts", longint'(write_sts_counter), 3);
      chk("wr_sts_err", longint'(write_sts_error_counter), 0);
      chk("rd_cmd_idle", longint'(read_cmd_counter), 0);
      chk("rd_word_idle", longint'(read_word_counter), 0);

      // Read status errors and a long data stall
      do_clear();
      for (int c = 0; c < 3; c++) begin
         tick(); idle(); rd_sts_tvalid = 1; rd_sts_tready = 1; rd_sts_tdata = rsts[c];
      end
      for (int c = 0; c < 10; c++) begin
         tick(); idle(); rd_data_tvalid = 1; rd_data_tready = 0; rd_data_tlast = 1;
      end
      tick(); idle(); tick(); tick();
      chk("rd_sts", longint'(read_sts_counter), 3);
      chk("rd_sts_err", longint'(read_sts_error_counter), 2);
      chk("rd_word_stall", longint'(read_word_counter), 0);
      chk("rd_pkg_stall", longint'(read_pkg_counter), 0);

      // All taps firing every cycle
      do_clear();
      for (int c = 0; c < 100; c++) begin
         tick();
         wr_cmd_tvalid = 1; wr_cmd_tready = 1; wr_cmd_tdata = 72'd1;
         wr_data_tvalid = 1; wr_data_tready = 1; wr_data_tlast = 1;
         wr_sts_tvalid = 1; wr_sts_tready = 1; wr_sts_tdata = 8'h00;
         rd_cmd_tvalid = 1; rd_cmd_tready = 1; rd_cmd_tdata = 72'd1;
         rd_data_tvalid = 1; rd_data_tready = 1; rd_data_tlast = 1;
         rd_sts_tvalid = 1; rd_sts_tready = 1; rd_sts_tdata = 8'h00;
      end
      tick(); idle(); tick();
      for (int k = 0; k < NC; k++) chk($sformatf("simul[%0d]", k), dut_val(k), 100);

      // Preload near the wrap point, then count across it
      force dut.write_word_d   = 32'hFFFF_FFFB;
      force dut.write_length_d = 48'hFFFF_FFFF_FFFF;
      base_val[1] = 64'hFFFF_FFFB;       base_edge[1] = e + 1;
      base_val[3] = 64'hFFFF_FFFF_FFFF;  base_edge[3] = e + 1;
      tick();
      release dut.write_word_d;
      release dut.write_length_d;
      for (int c = 0; c < 10; c++) begin
         idle();
         wr_data_tvalid = 1; wr_data_tready = 1;
         if (c == 0) begin
            wr_cmd_tvalid = 1; wr_cmd_tready = 1; wr_cmd_tdata = 72'd2;
         end
         tick();
      end
      idle(); tick(); tick();
      chk("wrap_word", longint'(write_word_counter), 5);
      chk("wrap_length", longint'(write_length_counter), 1);
      chk("wrap_cmd", longint'(write_cmd_counter), 101);

      // Clear pulse in the middle of back-to-back beats
      do_clear();
      for (int c = 0; c < 20; c++) begin
         tick();
         if (c == 11) chk("clear_zero", longint'(write_cmd_counter), 0);
         if (c == 12) chk("clear_flushed", longint'(write_cmd_counter), 0);
         if (c == 13) chk("clear_resume", longint'(write_cmd_counter), 1);
         idle();
         wr_cmd_tvalid = 1; wr_cmd_tready = 1; wr_cmd_tdata = 72'd1;
         stats_clear = (c == 10);
      end
      tick(); idle(); stats_clear = 0; tick(); tick();
      chk("clear_cmd_total", longint'(write_cmd_counter), 9);
      chk("clear_len_total", longint'(write_length_counter), 9);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
